// File: rtl/sram_ctl_pkg.sv
// Shared SRAM controller types and default sizing, also used by cache_manager_zgy.
package sram_ctl_pkg;

    localparam int unsigned NUM_OF_PORTS      = 16;
    localparam int unsigned DES_WIDTH         = 4;
    localparam int unsigned NUM_OF_PRIORITIES = 8;
    localparam int unsigned PRIORITY_WIDTH    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sram_rd_prio_pick.sv
// Strict-priority encoder for one port: lowest set queue index wins.
module sram_rd_prio_pick
    import sram_ctl_pkg::*;
#(
    parameter int unsigned num_of_priorities = NUM_OF_PRIORITIES,
    parameter int unsigned priority_width    = PRIORITY_WIDTH
) (
    input  logic [num_of_priorities-1:0] req,
    output logic                         found_c,
    output logic [priority_width-1:0]    idx_c
);

    // Scan from the least urgent down so the most urgent set bit is written last.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = num_of_priorities - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_c = 1'b1;
                idx_c   = priority_width'(i);
            end
        end
    end

endmodule

// File: rtl/sram_rd_scheduler.sv
// Packet read scheduler: round-robin over ports, strict priority within a port.
// Optional watchdog on the transfer phase: define RD_SCHED_TIMEOUT_EN.
module sram_rd_scheduler
    import sram_ctl_pkg::*;
#(
    parameter int unsigned num_of_ports      = NUM_OF_PORTS,
    parameter int unsigned des_width         = DES_WIDTH,
    parameter int unsigned num_of_priorities = NUM_OF_PRIORITIES,
    parameter int unsigned priority_width    = PRIORITY_WIDTH
`ifdef RD_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned timeout_cycles    = 4096
`endif
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [num_of_ports*num_of_priorities-1:0] queue_nonempty,
    input  logic [num_of_ports-1:0]                   port_ready,
    input  logic                                      rd_ack,
    input  logic                                      pkt_done,
    output logic                                      rd_valid,
    output logic [des_width-1:0]                      rd_port,
    output logic [priority_width-1:0]                 rd_priority,
    output logic                                      busy
`ifdef RD_SCHED_TIMEOUT_EN
    ,
    output logic                                      timeout_err
`endif
);

    rd_state_t                 state;
    rd_state_t                 state_next;
    logic [des_width-1:0]      rr_ptr;

    logic [num_of_ports-1:0]   found;
    logic [num_of_ports-1:0]   eligible_c;
    logic [priority_width-1:0] prio_idx [num_of_ports];

    logic                      win_found_c;
    logic [des_width-1:0]      win_port_c;
    logic [priority_width-1:0] win_prio_c;
    logic [des_width-1:0]      cand;
    logic                      tmo_hit_c;

    for (genvar p = 0; p < num_of_ports; p++) begin : g_port
        sram_rd_prio_pick #(
            .num_of_priorities (num_of_priorities),
            .priority_width    (priority_width)
        ) u_pick (
            .req     (queue_nonempty[p*num_of_priorities +: num_of_priorities]),
            .found_c (found[p]),
            .idx_c   (prio_idx[p])
        );
        assign eligible_c[p] = port_ready[p] & found[p];
    end

    // Round-robin search starting at rr_ptr; index arithmetic wraps at 2^des_width.
    always_comb begin
        win_found_c = 1'b0;
        win_port_c  = '0;
        win_prio_c  = '0;
        cand        = '0;
        for (int k = 0; k < num_of_ports; k++) begin
            cand = rr_ptr + des_width'(k);
            if (!win_found_c && eligible_c[cand]) begin
                win_found_c = 1'b1;
                win_port_c  = cand;
                win_prio_c  = prio_idx[cand];
            end
        end
    end

`ifdef RD_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(timeout_cycles + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the cycle that completes timeout_cycles in XFER; pkt_done wins a tie.
    assign tmo_hit_c = (state == XFER) && !pkt_done
                     && (tmo_cnt == TMO_W'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit_c;
            if (state != XFER) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found_c)            state_next = GRANT;
            GRANT:   if (rd_ack)                 state_next = XFER;
            XFER:    if (pkt_done || tmo_hit_c)  state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            rd_port     <= '0;
            rd_priority <= '0;
            rr_ptr      <= '0;
        end else begin
            rd_valid <= (state_next == GRANT);
            busy     <= (state_next != IDLE);
            if (state == IDLE && win_found_c) begin
                rd_port     <= win_port_c;
                rd_priority <= win_prio_c;
                rr_ptr      <= win_port_c + des_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_rd_scheduler.sv
// Directed plus randomized bench for sram_rd_scheduler with a behavioural grant model.
module tb_sram_rd_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] qne;
    logic [15:0]  rdy;
    logic         rd_ack;
    logic         pkt_done;
    logic         rd_valid;
    logic [3:0]   rd_port;
    logic [2:0]   rd_priority;
    logic         busy;
`ifdef RD_SCHED_TIMEOUT_EN
    logic         timeout_err;
`endif

    int passed = 0;
    int total  = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

`ifdef RD_SCHED_TIMEOUT_EN
    sram_rd_scheduler #(.timeout_cycles(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .queue_nonempty (qne),
        .port_ready     (rdy),
        .rd_ack         (rd_ack),
        .pkt_done       (pkt_done),
        .rd_valid       (rd_valid),
        .rd_port        (rd_port),
        .rd_priority    (rd_priority),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );
`else
    sram_rd_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .queue_nonempty (qne),
        .port_ready     (rdy),
        .rd_ack         (rd_ack),
        .pkt_done       (pkt_done),
        .rd_valid       (rd_valid),
        .rd_port        (rd_port),
        .rd_priority    (rd_priority),
        .busy           (busy)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: first ready port with any queue, from ptr upward; lowest set priority.
    function automatic void predict(input logic [127:0] q, input logic [15:0] r, input int ptr,
                                    output bit f, output int port, output int prio);
        int p;
        f = 1'b0;
        port = 0;
        prio = 0;
        for (int k = 0; k < 16; k++) begin
            p = (ptr + k) % 16;
            if (!f && r[p] && q[p*8 +: 8] != 8'h00) begin
                f = 1'b1;
                port = p;
                for (int j = 7; j >= 0; j--) if (q[p*8 + j]) prio = j;
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        qne = '0;
        rdy = '0;
        rd_ack = 1'b0;
        pkt_done = 1'b0;
        tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // One decision from the current inputs; mode 1 scrambles inputs during GRANT, mode 2 clears them.
    task automatic do_grant(input int ack_dly, input int done_dly, input int mode);
        bit f;
        int ep;
        int epr;
        predict(qne, rdy, m_ptr, f, ep, epr);
        tick();
        if (!f) begin
            chk("idle_valid", 32'(rd_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            return;
        end
        chk("grant_valid", 32'(rd_valid), 32'd1);
        chk("grant_port", 32'(rd_port), 32'(ep));
        chk("grant_prio", 32'(rd_priority), 32'(epr));
        chk("grant_busy", 32'(busy), 32'd1);
        m_ptr = (ep + 1) % 16;
        for (int i = 0; i < ack_dly; i++) begin
            if (mode == 1) begin
                qne = {$urandom, $urandom, $urandom, $urandom};
                rdy = 16'($urandom);
            end else if (mode == 2) begin
                qne = '0;
            end
            pkt_done = 1'($urandom_range(0, 1));
            tick();
            pkt_done = 1'b0;
            chk("hold_valid", 32'(rd_valid), 32'd1);
            chk("hold_port", 32'(rd_port), 32'(ep));
            chk("hold_prio", 32'(rd_priority), 32'(epr));
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("xfer_valid", 32'(rd_valid), 32'd0);
        chk("xfer_busy", 32'(busy), 32'd1);
        for (int i = 0; i < done_dly; i++) begin
            rd_ack = 1'($urandom_range(0, 1));
            tick();
            rd_ack = 1'b0;
            chk("xfer_wait_busy", 32'(busy), 32'd1);
        end
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(rd_valid), 32'd0);
        chk("done_port_kept", 32'(rd_port), 32'(ep));
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_port", 32'(rd_port), 32'd0);
        chk("rst_prio", 32'(rd_priority), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single queue (0,0)
        qne[0] = 1'b1;
        rdy = '1;
        do_grant(0, 0, 0);

        // Port 3 with priorities 1 and 5, then only 5
        qne = '0;
        qne[3*8 + 1] = 1'b1;
        qne[3*8 + 5] = 1'b1;
        do_grant(0, 1, 0);
        qne[3*8 + 1] = 1'b0;
        do_grant(1, 0, 0);

        // Nothing eligible
        qne = '0;
        qne[9*8 + 3] = 1'b1;
        rdy = '1;
        rdy[9] = 1'b0;
        do_grant(0, 0, 0);
        do_grant(0, 0, 0);

        // Full round-robin sweep
        do_reset();
        rdy = '1;
        for (int p = 0; p < 16; p++) qne[p*8 + 2] = 1'b1;
        for (int g = 0; g < 17; g++) do_grant(0, 0, 0);

        // Port 4 not ready is skipped, then granted once ready
        do_reset();
        qne[4*8 + 0] = 1'b1;
        qne[7*8 + 6] = 1'b1;
        rdy = '1;
        rdy[4] = 1'b0;
        do_grant(0, 0, 0);
        qne[7*8 + 6] = 1'b0;
        rdy[4] = 1'b1;
        do_grant(0, 0, 0);

        // Grant held without ack while queues drain, then reset in XFER
        do_reset();
        qne[2*8 + 4] = 1'b1;
        rdy = '1;
        tick();
        chk("hold2_valid", 32'(rd_valid), 32'd1);
        chk("hold2_port", 32'(rd_port), 32'd2);
        qne = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold2_valid_n", 32'(rd_valid), 32'd1);
            chk("hold2_port_n", 32'(rd_port), 32'd2);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("hold2_xfer_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        chk("xrst_valid", 32'(rd_valid), 32'd0);
        chk("xrst_busy", 32'(busy), 32'd0);
        chk("xrst_port", 32'(rd_port), 32'd0);
        qne[1*8 + 7] = 1'b1;
        qne[5*8 + 0] = 1'b1;
        do_grant(0, 0, 0);

`ifdef RD_SCHED_TIMEOUT_EN
        begin
            int n;
            do_reset();
            qne[0] = 1'b1;
            rdy = '1;
            tick();
            rd_ack = 1'b1;
            tick();
            rd_ack = 1'b0;
            qne = '0;
            n = 0;
            while (timeout_err !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("tmo_delay", 32'(n), 32'd8);
            chk("tmo_busy", 32'(busy), 32'd0);
            tick();
            chk("tmo_single_pulse", 32'(timeout_err), 32'd0);
            m_ptr = 1;
        end
`endif

        // Randomized traffic
        do_reset();
        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < 16; p++)
                qne[p*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rdy = 16'($urandom);
            do_grant($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_rd_scheduler.md
# sram_rd_scheduler

Packet-level read scheduler for the shared-SRAM cache manager. It decides which (destination port, priority) queue is dequeued next and presents that choice as a single read request. Ports are arbitrated round-robin. Within a port, queues are arbitrated by strict priority. It sits between the output-port read side and the cache manager's per-port `next_data` / `priority_from_rd_ar` inputs, and holds a grant until the granted packet's end-of-packet is returned.

## Interface
Parameters:
- num_of_ports, 16, number of destination ports
- des_width, 4, port index width
- num_of_priorities, 8, queues per port
- priority_width, 3, priority index width; value 0 is the most urgent
- timeout_cycles, 4096, watchdog limit in cycles; used only when the timeout feature is compiled in

Ports (clock and reset first):
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- queue_nonempty  in  num_of_ports*num_of_priorities  bit p*num_of_priorities+q is set when queue (p,q) holds at least one complete packet
- port_ready  in  num_of_ports  output port p can accept a new packet
- rd_ack  in  1  cache manager accepts the presented request
- pkt_done  in  1  one-cycle pulse: eop of the granted packet has been read out
- rd_valid  out  1  request presented
- rd_port  out  des_width  granted port
- rd_priority  out  priority_width  granted priority
- busy  out  1  state is not IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog fires; exists only when RD_SCHED_TIMEOUT_EN is defined

## Operation
- FSM states: IDLE, GRANT, XFER.
- **IDLE**
  - A port p is eligible when `port_ready[p]` is set and at least one of its queues is non-empty.
  - Search ports starting at rr_ptr, increasing with wrap-around. The first eligible port wins.
  - Within the winning port, the lowest non-empty priority index wins.
  - If a winner exists: register rd_port and rd_priority, set rr_ptr = (p+1) mod num_of_ports, go to GRANT.
  - If no port is eligible, stay in IDLE.
- **GRANT**
  - rd_valid = 1. rd_port and rd_priority are held stable.
  - Changes on queue_nonempty or port_ready are ignored; the grant is never retracted.
  - rd_ack moves the FSM to XFER. pkt_done is ignored in this state.
- **XFER**
  - rd_valid = 0.
  - pkt_done moves the FSM to IDLE. rd_port and rd_priority keep their last value.
- rd_ack outside GRANT and pkt_done outside XFER have no effect.
- rr_ptr wraps from num_of_ports-1 to 0. It is des_width bits; num_of_ports must equal 2^des_width.
- Reset outputs: rd_valid=0, rd_port=0, rd_priority=0, busy=0, timeout_err=0. Reset also sets rr_ptr=0 and state=IDLE.

## Timing
- rd_valid rises on the cycle after IDLE samples an eligible port (1-cycle decision latency).
- rd_ack may be high in the first rd_valid cycle. XFER is entered on the next edge.
- pkt_done is legal from the first XFER cycle onward.
- Every packet spends at least one cycle in each state, so back-to-back grants are at least 3 cycles apart.
- Reset asserted in any state returns the FSM to IDLE on the next edge with reset output values. An in-flight grant is dropped silently.

## Configuration
- RD_SCHED_TIMEOUT_EN defined:
  - A counter of width $clog2(timeout_cycles+1) clears on XFER entry and increments each cycle in XFER.
  - When the counter reaches timeout_cycles without pkt_done: timeout_err pulses for 1 cycle and the FSM returns to IDLE.
  - pkt_done arriving in the same cycle as the timeout takes precedence; no error pulse is raised.
- RD_SCHED_TIMEOUT_EN undefined: no counter and no timeout_err port. XFER waits indefinitely for pkt_done.

## Structure
- Shared package sram_ctl_pkg: FSM state typedef (IDLE/GRANT/XFER) and default constants for num_of_ports, num_of_priorities, des_width and priority_width, shared with cache_manager_zgy.
- One sub-module, sram_rd_prio_pick: combinational strict-priority encoder for a single port. Input is num_of_priorities bits; outputs are a found flag and the index. It is instantiated once per port.

## Test plan
- Reset, then queue (0,0) non-empty and port_ready=all-ones → rd_valid=1 one cycle later with rd_port=0, rd_priority=0. After rd_ack and then pkt_done, busy=0.
- Port 3 with priorities 1 and 5 non-empty → rd_priority=1. After that packet completes with only priority 5 left → next grant is rd_priority=5.
- All 16 ports holding priority-2 packets, ack and done returned immediately → grants visit ports 0,1,…,15,0 in order, 3 cycles apart.
- Queue (4,0) non-empty but port_ready[4]=0, and queue (7,6) non-empty → grant goes to port 7. Port 4 is granted after port_ready[4] rises.
- Port 2 granted, rd_valid held 5 cycles with no rd_ack while queue_nonempty drops to 0 → rd_port=2 held stable throughout. Reset in XFER → rd_valid=0 and busy=0 next cycle, and the following grant searches from port 0.
- With RD_SCHED_TIMEOUT_EN and timeout_cycles=8, enter XFER with no pkt_done → timeout_err pulses exactly once, 8 cycles after XFER entry, and the FSM returns to IDLE.
